aespim_ctrl: RTL and testbench
==============================

# aespim_ctrl

Command sequencer for the AES/GF processing-in-memory accelerator. Accepts one multi-word command from the core (opcode, base address, word count, register operand). For each word it fetches the memory operand over an OBI-style data port, pulses the accelerator's start with the packed 6-bit op code, and writes accelerator results back to memory. It sits between the core's accelerator command interface and both the accelerator and the data bus.

## Interface
Parameters:
- None; all widths fixed (32-bit data/address, 3-bit beat counter).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  command accepted when valid&ready; high only in IDLE
- cmd_op_i  in  3  accelerator op (aespim_pkg op encoding)
- cmd_sr_i  in  3  shift-row/GF select field
- cmd_addr_i  in  32  byte address of first word
- cmd_len_i  in  3  number of word beats, 0..7
- cmd_reg_i  in  32  register operand, held for whole command
- busy_o  out  1  high whenever state != IDLE
- done_o  out  1  one-cycle pulse at command completion
- data_req_o / data_gnt_i  out/in  1  bus request / grant
- data_we_o  out  1  write enable
- data_addr_o  out  32  word address
- data_wdata_o  out  32  write data
- data_rvalid_i  in  1  response valid (reads and writes)
- data_rdata_i  in  32  read data
- acc_start_o  out  1  one-cycle accelerator start
- acc_op_code_o  out  6  {sr[2:0], op[2:0]}
- acc_data_mem_o  out  32  latched memory word
- acc_data_reg_o  out  32  latched cmd_reg_i
- acc_data_i  in  32  accelerator data output

## Operation
- Opcode classes (package function):
  - READ: OP_LD, OP_ENCI, OP_ENCF, OP_GMUL.
  - WRITE: OP_ST, OP_KEXI, OP_KEX.
  - EXEC: all other codes.
- FSM states: IDLE, RREQ, RWAIT, EXEC, WREQ, WWAIT, DONE.
- IDLE: on accept, latch op, sr, addr, len, reg; clear beat index.
  - len==0 goes to DONE.
  - Otherwise READ goes to RREQ; WRITE and EXEC go to EXEC.
- RREQ: data_req_o=1, we=0, addr=current address. Hold until data_gnt_i, then go to RWAIT.
- RWAIT: on data_rvalid_i, latch data_rdata_i into acc_data_mem_o, then go to EXEC.
- EXEC: acc_start_o=1 for exactly this cycle.
  - WRITE class: capture acc_data_i into the wdata register this cycle (pre-update state), then go to WREQ.
  - Otherwise: beat ends.
- WREQ: req=1, we=1, wdata held. Hold until gnt, then go to WWAIT. WWAIT: on rvalid, beat ends.
- Beat end: beat index +1, address +4 (32-bit wrap, 0xFFFFFFFC -> 0x0). If index==len go to DONE, else start next beat in the class's first state.
- DONE: done_o=1, then IDLE.
- data_addr_o, data_we_o, data_wdata_o hold their values while req is high and unchanged until gnt; req never drops before gnt.
- rvalid outside RWAIT/WWAIT is ignored. gnt and rvalid in the same cycle in RREQ/WREQ: rvalid is also consumed, moving directly to the RWAIT/WWAIT exit action.
- Reset mid-command: FSM returns to IDLE and all registers clear; no done_o.

## Timing
- Reset values:
  - cmd_ready_o=1.
  - busy_o, done_o, data_req_o, data_we_o, acc_start_o = 0.
  - All data/address outputs and acc_op_code_o = 0.
- Read beat, zero-wait gnt and rvalid next cycle: 3 cycles (RREQ, RWAIT, EXEC).
- Exec beat: 1 cycle. Write beat (zero wait): 3 cycles.
- done_o fires the cycle after the last beat ends. cmd_ready_o returns the cycle after DONE.
- acc_op_code_o is valid and stable whenever acc_start_o=1.

## Configuration
- AESPIM_CTRL_SR_AUTO_EN defined: for OP_ENCI/OP_ENCM/OP_ENCF, sr = beat index[2:0]; other ops use cmd_sr_i.
- Not defined: sr = cmd_sr_i for all ops and beats.

## Structure
- aespim_pkg additions:
  - aespim_ctrl_state_e enum.
  - aespim_op_class_e {OPC_READ, OPC_WRITE, OPC_EXEC}.
  - Function op_class(op) returning the class.
- Existing op constants are reused from aespim_pkg.
- No sub-module; FSM, beat counter, address and data registers live in one module.

## Test plan
- OP_LD, len=4, addr=0x100, zero-wait bus: reads 0x100/104/108/10C; 4 start pulses, each op_code={cmd_sr,OP_LD}; acc_data_mem_o equals each rdata at its start; done_o after 12 cycles.
- OP_ST, len=2, acc_data_i=0xA5A5A5A5 then 0x5A5A5A5A: two writes of those values at addr and addr+4, we=1; done_o pulses once.
- OP_ENCI, len=4, cmd_sr=0, AESPIM_CTRL_SR_AUTO_EN on: sr fields 0,1,2,3. Macro off: all 0.
- gnt stalled 3 cycles, then gnt with rvalid in the same cycle: req held with stable addr; no extra request; beat completes.
- len=0: done_o the cycle after accept, no req, no start. addr=0xFFFFFFFC with len=2 wraps to 0x0.
- rst_ni low during RWAIT of beat 2: all outputs 0 next edge; cmd_ready_o=1; no done_o; a new command runs normally.

Source files
------------

// File: rtl/aespim_pkg.sv
// rtl/aespim_pkg.sv - shared types and helpers for the AES/GF PIM accelerator
//
// Purpose: accelerator op encoding, command-sequencer state and op-class enums,
//          and the op classification helpers used by aespim_ctrl.
// Ports:   none (package).
package aespim_pkg;

  typedef enum logic [2:0] {
    OP_LD   = 3'd0,
    OP_ST   = 3'd1,
    OP_ENCI = 3'd2,
    OP_ENCM = 3'd3,
    OP_ENCF = 3'd4,
    OP_GMUL = 3'd5,
    OP_KEXI = 3'd6,
    OP_KEX  = 3'd7
  } aespim_op_e;

  typedef enum logic [1:0] {
    OPC_READ,
    OPC_WRITE,
    OPC_EXEC
  } aespim_op_class_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RREQ,
    ST_RWAIT,
    ST_EXEC,
    ST_WREQ,
    ST_WWAIT,
    ST_DONE
  } aespim_ctrl_state_e;

  // Byte stride between consecutive word beats.
  localparam logic [31:0] WORD_STRIDE = 32'd4;

  // READ ops need a memory operand before start; WRITE ops store the
  // accelerator result afterwards; everything else only pulses start.
  function automatic aespim_op_class_e op_class(input aespim_op_e op);
    aespim_op_class_e cls;
    cls = OPC_EXEC;
    case (op)
      OP_LD, OP_ENCI, OP_ENCF, OP_GMUL: cls = OPC_READ;
      OP_ST, OP_KEXI, OP_KEX:           cls = OPC_WRITE;
      default:                          cls = OPC_EXEC;
    endcase
    return cls;
  endfunction

  // AES round ops, whose shift-row field can follow the beat index.
  function automatic logic is_enc_op(input aespim_op_e op);
    return (op == OP_ENCI) || (op == OP_ENCM) || (op == OP_ENCF);
  endfunction

endpackage

// File: rtl/aespim_ctrl_if.sv
// rtl/aespim_ctrl_if.sv - command, data-bus and accelerator signal bundle
//
// Purpose: groups the core command handshake, the OBI-style data port and
//          the accelerator start/operand signals of aespim_ctrl.
// Signals:
//   cmd_valid/cmd_ready, cmd_op[2:0], cmd_sr[2:0], cmd_addr[31:0],
//   cmd_len[2:0], cmd_reg[31:0]                       core command
//   data_req/data_gnt, data_we, data_addr[31:0], data_wdata[31:0],
//   data_rvalid, data_rdata[31:0]                     memory data port
//   acc_start, acc_op_code[5:0], acc_data_mem[31:0],
//   acc_data_reg[31:0], acc_data[31:0]                accelerator
// Modports: master = sequencer side, slave = core/memory/accelerator side.
interface aespim_ctrl_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_sr;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_len;
  logic [31:0] cmd_reg;

  logic        data_req;
  logic        data_gnt;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_rvalid;
  logic [31:0] data_rdata;

  logic        acc_start;
  logic [5:0]  acc_op_code;
  logic [31:0] acc_data_mem;
  logic [31:0] acc_data_reg;
  logic [31:0] acc_data;

  modport master (
    input  cmd_valid, cmd_op, cmd_sr, cmd_addr, cmd_len, cmd_reg,
    output cmd_ready,
    output data_req, data_we, data_addr, data_wdata,
    input  data_gnt, data_rvalid, data_rdata,
    output acc_start, acc_op_code, acc_data_mem, acc_data_reg,
    input  acc_data
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_sr, cmd_addr, cmd_len, cmd_reg,
    input  cmd_ready,
    input  data_req, data_we, data_addr, data_wdata,
    output data_gnt, data_rvalid, data_rdata,
    input  acc_start, acc_op_code, acc_data_mem, acc_data_reg,
    output acc_data
  );

endinterface

// File: rtl/aespim_ctrl.sv
// rtl/aespim_ctrl.sv - multi-word command sequencer for the AES/GF PIM accelerator
//
// Purpose: accepts one command (op, sr, base address, word count, register
//          operand) and, per word beat, fetches the memory operand, pulses
//          the accelerator start and stores accelerator results back.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   bus     aespim_ctrl_if.master (command, data port, accelerator)
//   busy_o  high whenever a command is in flight
//   done_o  one-cycle pulse at command completion
// Configuration:
//   AESPIM_CTRL_SR_AUTO_EN  when defined, AES round ops take their shift-row
//                           field from the beat index instead of cmd_sr.
module aespim_ctrl
  import aespim_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_ni,
  aespim_ctrl_if.master bus,
  output logic          busy_o,
  output logic          done_o
);

  aespim_ctrl_state_e state_q, state_d;

  aespim_op_e  op_q;
  logic [2:0]  sr_q;
  logic [2:0]  len_q;
  logic [2:0]  idx_q;
  logic [31:0] addr_q;
  logic [31:0] reg_q;
  logic [31:0] mem_q;
  logic [31:0] wdata_q;

  logic accept;
  logic cap_rdata;
  logic cap_wdata;
  logic beat_end;
  logic last_beat;
  logic [2:0] sr_eff;

  aespim_op_e       cmd_op;
  aespim_op_class_e cmd_cls;
  aespim_op_class_e cur_cls;

  assign cmd_op    = aespim_op_e'(bus.cmd_op);
  assign cmd_cls   = op_class(cmd_op);
  assign cur_cls   = op_class(op_q);
  assign last_beat = (idx_q + 3'd1) == len_q;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    cap_rdata = 1'b0;
    cap_wdata = 1'b0;
    beat_end  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          accept = 1'b1;
          if (bus.cmd_len == 3'd0) begin
            state_d = ST_DONE;
          end else if (cmd_cls == OPC_READ) begin
            state_d = ST_RREQ;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_RREQ: begin
        if (bus.data_gnt) begin
          // A response arriving together with the grant is taken at once.
          if (bus.data_rvalid) begin
            cap_rdata = 1'b1;
            state_d   = ST_EXEC;
          end else begin
            state_d = ST_RWAIT;
          end
        end
      end
      ST_RWAIT: begin
        if (bus.data_rvalid) begin
          cap_rdata = 1'b1;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cur_cls == OPC_WRITE) begin
          cap_wdata = 1'b1;
          state_d   = ST_WREQ;
        end else begin
          beat_end = 1'b1;
        end
      end
      ST_WREQ: begin
        if (bus.data_gnt) begin
          if (bus.data_rvalid) begin
            beat_end = 1'b1;
          end else begin
            state_d = ST_WWAIT;
          end
        end
      end
      ST_WWAIT: begin
        if (bus.data_rvalid) begin
          beat_end = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Beat completion overrides the per-state target: either finish or
    // restart the beat in the first state of the op's class.
    if (beat_end) begin
      if (last_beat) begin
        state_d = ST_DONE;
      end else if (cur_cls == OPC_READ) begin
        state_d = ST_RREQ;
      end else begin
        state_d = ST_EXEC;
      end
    end
  end

  // Command, beat counter, address and operand registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q    <= OP_LD;
      sr_q    <= 3'd0;
      len_q   <= 3'd0;
      idx_q   <= 3'd0;
      addr_q  <= 32'd0;
      reg_q   <= 32'd0;
      mem_q   <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      if (accept) begin
        op_q   <= cmd_op;
        sr_q   <= bus.cmd_sr;
        len_q  <= bus.cmd_len;
        idx_q  <= 3'd0;
        addr_q <= bus.cmd_addr;
        reg_q  <= bus.cmd_reg;
      end
      if (cap_rdata) begin
        mem_q <= bus.data_rdata;
      end
      if (cap_wdata) begin
        wdata_q <= bus.acc_data;
      end
      if (beat_end) begin
        idx_q  <= idx_q + 3'd1;
        addr_q <= addr_q + WORD_STRIDE;  // wraps naturally at 2^32
      end
    end
  end

`ifdef AESPIM_CTRL_SR_AUTO_EN
  assign sr_eff = is_enc_op(op_q) ? idx_q : sr_q;
`else
  assign sr_eff = sr_q;
`endif

  // All bus/accelerator outputs come straight from registers or the state,
  // so address, write enable and write data stay stable while req waits.
  assign bus.cmd_ready    = (state_q == ST_IDLE);
  assign bus.data_req     = (state_q == ST_RREQ) || (state_q == ST_WREQ);
  assign bus.data_we      = (state_q == ST_WREQ);
  assign bus.data_addr    = addr_q;
  assign bus.data_wdata   = wdata_q;
  assign bus.acc_start    = (state_q == ST_EXEC);
  assign bus.acc_op_code  = {sr_eff, op_q};
  assign bus.acc_data_mem = mem_q;
  assign bus.acc_data_reg = reg_q;

  assign busy_o = (state_q != ST_IDLE);
  assign done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_aespim_ctrl.sv
// tb/tb_aespim_ctrl.sv - scoreboard bench for aespim_ctrl
module tb_aespim_ctrl;
  import aespim_pkg::*;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic busy_o, done_o;

  aespim_ctrl_if bus ();

  aespim_ctrl dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus),
    .busy_o (busy_o),
    .done_o (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic [5:0]  code;
    logic [31:0] mem;
    logic [31:0] regv;
  } start_exp_t;

  bus_exp_t    exp_bus[$];
  start_exp_t  exp_start[$];
  int          exp_done[$];
  logic [31:0] rd_q[$];
  logic [31:0] acc_q[$];
  logic [31:0] fixed_acc[$];

  int n_cmp = 0;
  int n_err = 0;
  int n_starts = 0;

  bit   zero_wait = 1'b1;
  int   force_stall = -1;
  bit   force_same = 1'b0;
  logic [31:0] model_mem = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // Reference classification, written from the op lists.
  function automatic int model_class(input logic [2:0] op);
    if (op inside {OP_LD, OP_ENCI, OP_ENCF, OP_GMUL}) return 0;  // read
    if (op inside {OP_ST, OP_KEXI, OP_KEX})           return 1;  // write
    return 2;                                                    // exec
  endfunction

  function automatic int zw_latency(input logic [2:0] op, input logic [2:0] len);
    return 1 + int'(len) * ((model_class(op) == 2) ? 1 : 3);
  endfunction

  // Memory responder: decisions made at negedge for the next posedge.
  initial begin
    bit outstanding, out_we, hs_last, rv_last;
    int stall_left;
    bus.data_gnt = 1'b0; bus.data_rvalid = 1'b0; bus.data_rdata = 32'h0;
    outstanding = 0; out_we = 0; hs_last = 0; rv_last = 0; stall_left = -1;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        bus.data_gnt = 1'b0; bus.data_rvalid = 1'b0;
        outstanding = 0; hs_last = 0; rv_last = 0; stall_left = -1;
      end else begin
        if (hs_last && !rv_last) outstanding = 1;
        else if (rv_last) outstanding = 0;
        bus.data_gnt = 1'b0; bus.data_rvalid = 1'b0;
        hs_last = 0;
        if (outstanding) begin
          if (zero_wait || $urandom_range(0, 2) != 0) begin
            bus.data_rvalid = 1'b1;
            if (!out_we && rd_q.size() > 0) bus.data_rdata = rd_q.pop_front();
            else bus.data_rdata = $urandom;
          end
        end else if (bus.data_req) begin
          if (stall_left < 0)
            stall_left = zero_wait ? 0 : ((force_stall >= 0) ? force_stall : $urandom_range(0, 3));
          if (stall_left > 0) begin
            stall_left--;
          end else begin
            bus.data_gnt = 1'b1;
            hs_last = 1;
            stall_left = -1;
            out_we = bus.data_we;
            if (!zero_wait && (force_same || $urandom_range(0, 2) == 0)) begin
              bus.data_rvalid = 1'b1;
              if (!out_we && rd_q.size() > 0) bus.data_rdata = rd_q.pop_front();
              else bus.data_rdata = $urandom;
            end
          end
        end else if (!zero_wait && $urandom_range(0, 4) == 0) begin
          // Stray response outside a wait state must be ignored.
          bus.data_rvalid = 1'b1;
          bus.data_rdata = $urandom;
        end
        rv_last = bus.data_rvalid;
      end
    end
  end

  // Accelerator result: the value for the pending start, updated after each edge.
  initial begin
    bus.acc_data = 32'h0;
    forever begin
      @(posedge clk_i);
      #1;
      bus.acc_data = (acc_q.size() > 0) ? acc_q[0] : 32'h0;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a bus handshake,
  // a start pulse or a done pulse.
  initial begin
    bus_exp_t    be;
    start_exp_t  se;
    bit          pend;
    logic [31:0] p_addr, p_wdata;
    logic        p_we;
    pend = 0;
    forever begin
      @(negedge clk_i);
      #1;
      if (!rst_ni) begin
        pend = 0;
      end else begin
        if (pend) begin
          chk("req_held", {31'h0, bus.data_req}, 32'h1);
          chk("addr_held", bus.data_addr, p_addr);
          chk("we_held", {31'h0, bus.data_we}, {31'h0, p_we});
          chk("wdata_held", bus.data_wdata, p_wdata);
        end
        pend = 0;
        if (bus.data_req && !bus.data_gnt) begin
          pend = 1; p_addr = bus.data_addr; p_we = bus.data_we; p_wdata = bus.data_wdata;
        end
        if (bus.data_req && bus.data_gnt) begin
          if (exp_bus.size() == 0) begin
            fail("unexpected_req");
          end else begin
            be = exp_bus.pop_front();
            chk("bus_addr", bus.data_addr, be.addr);
            chk("bus_we", {31'h0, bus.data_we}, {31'h0, be.we});
            if (be.we) chk("bus_wdata", bus.data_wdata, be.wdata);
          end
        end
        if (bus.acc_start) begin
          n_starts++;
          if (acc_q.size() > 0) void'(acc_q.pop_front());
          if (exp_start.size() == 0) begin
            fail("unexpected_start");
          end else begin
            se = exp_start.pop_front();
            chk("op_code", {26'h0, bus.acc_op_code}, {26'h0, se.code});
            chk("acc_mem", bus.acc_data_mem, se.mem);
            chk("acc_reg", bus.acc_data_reg, se.regv);
          end
        end
        if (done_o) begin
          if (exp_done.size() == 0) fail("unexpected_done");
          else void'(exp_done.pop_front());
        end
      end
    end
  end

  task automatic issue_cmd(input logic [2:0] op, input logic [2:0] sr, input logic [31:0] addr,
                           input logic [2:0] len, input logic [31:0] regv);
    int          cls, t;
    logic [31:0] a, v, rd;
    logic [2:0]  s;
    cls = model_class(op);
    for (int b = 0; b < int'(len); b++) begin
      a = addr + 32'(4 * b);
      s = sr;
`ifdef AESPIM_CTRL_SR_AUTO_EN
      if (op inside {OP_ENCI, OP_ENCM, OP_ENCF}) s = 3'(b);
`endif
      if (fixed_acc.size() > 0) v = fixed_acc.pop_front();
      else v = $urandom;
      acc_q.push_back(v);
      if (cls == 0) begin
        rd = $urandom;
        rd_q.push_back(rd);
        exp_bus.push_back('{addr: a, we: 1'b0, wdata: 32'h0});
        model_mem = rd;
      end
      exp_start.push_back('{code: {s, op}, mem: model_mem, regv: regv});
      if (cls == 1) exp_bus.push_back('{addr: a, we: 1'b1, wdata: v});
    end
    exp_done.push_back(1);
    t = 0;
    while (!bus.cmd_ready && t < 200) begin
      @(negedge clk_i); #2; t++;
    end
    if (!bus.cmd_ready) fail("cmd_ready_timeout");
    bus.cmd_op = op; bus.cmd_sr = sr; bus.cmd_addr = addr; bus.cmd_len = len; bus.cmd_reg = regv;
    bus.cmd_valid = 1'b1;
    @(posedge clk_i);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [2:0] sr, input logic [31:0] addr,
                         input logic [2:0] len, input logic [31:0] regv, input int exp_lat);
    int cyc;
    bit got;
    issue_cmd(op, sr, addr, len, regv);
    cyc = 0; got = 0;
    while (!got && cyc < 400) begin
      @(negedge clk_i); #2; cyc++;
      if (done_o) got = 1;
    end
    if (!got) begin
      fail("done_timeout");
    end else begin
      if (exp_lat >= 0) chk("done_latency", 32'(cyc), 32'(exp_lat));
      @(negedge clk_i); #2;
      chk("ready_after_done", {31'h0, bus.cmd_ready}, 32'h1);
      chk("done_one_cycle", {31'h0, done_o}, 32'h0);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_ready"}, {31'h0, bus.cmd_ready}, 32'h1);
    chk({tag, "_busy"}, {31'h0, busy_o}, 32'h0);
    chk({tag, "_done"}, {31'h0, done_o}, 32'h0);
    chk({tag, "_req"}, {31'h0, bus.data_req}, 32'h0);
    chk({tag, "_we"}, {31'h0, bus.data_we}, 32'h0);
    chk({tag, "_start"}, {31'h0, bus.acc_start}, 32'h0);
    chk({tag, "_addr"}, bus.data_addr, 32'h0);
    chk({tag, "_wdata"}, bus.data_wdata, 32'h0);
    chk({tag, "_opcode"}, {26'h0, bus.acc_op_code}, 32'h0);
    chk({tag, "_mem"}, bus.acc_data_mem, 32'h0);
    chk({tag, "_reg"}, bus.acc_data_reg, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    int          t, st0;
    logic [2:0]  op, sr, len;
    logic [31:0] addr;

    rst_ni = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = 3'd0; bus.cmd_sr = 3'd0;
    bus.cmd_addr = 32'h0; bus.cmd_len = 3'd0; bus.cmd_reg = 32'h0;
    repeat (3) @(negedge clk_i);
    #2;
    check_idle_outputs("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Zero-wait directed commands.
    zero_wait = 1'b1;
    run_cmd(OP_LD, 3'd5, 32'h0000_0100, 3'd4, 32'hCAFE_0001, zw_latency(OP_LD, 3'd4));
    fixed_acc.push_back(32'hA5A5_A5A5);
    fixed_acc.push_back(32'h5A5A_5A5A);
    run_cmd(OP_ST, 3'd2, 32'h0000_0200, 3'd2, 32'hCAFE_0002, zw_latency(OP_ST, 3'd2));
    run_cmd(OP_ENCI, 3'd0, 32'h0000_0300, 3'd4, 32'hCAFE_0003, zw_latency(OP_ENCI, 3'd4));
    run_cmd(OP_ENCM, 3'd3, 32'h0000_0400, 3'd3, 32'hCAFE_0004, zw_latency(OP_ENCM, 3'd3));
    run_cmd(OP_LD, 3'd1, 32'h0000_0500, 3'd0, 32'hCAFE_0005, 1);
    run_cmd(OP_ST, 3'd1, 32'hFFFF_FFFC, 3'd2, 32'hCAFE_0006, zw_latency(OP_ST, 3'd2));
    run_cmd(OP_GMUL, 3'd7, 32'hFFFF_FFF8, 3'd3, 32'hCAFE_0007, zw_latency(OP_GMUL, 3'd3));

    // Stalled grant with response in the grant cycle.
    zero_wait = 1'b0; force_stall = 3; force_same = 1'b1;
    run_cmd(OP_LD, 3'd4, 32'h0000_0600, 3'd2, 32'hCAFE_0008, -1);
    run_cmd(OP_KEX, 3'd6, 32'h0000_0700, 3'd2, 32'hCAFE_0009, -1);
    force_stall = -1; force_same = 1'b0;

    // Reset during the read wait of beat 2.
    zero_wait = 1'b1;
    st0 = n_starts;
    issue_cmd(OP_LD, 3'd2, 32'h0000_0800, 3'd4, 32'h1234_5678);
    t = 0;
    while (n_starts < st0 + 1 && t < 50) begin
      @(negedge clk_i); #2; t++;
    end
    if (n_starts < st0 + 1) fail("first_start_timeout");
    @(negedge clk_i); #2;
    @(negedge clk_i); #2;
    chk("rwait_busy", {31'h0, busy_o}, 32'h1);
    chk("rwait_no_req", {31'h0, bus.data_req}, 32'h0);
    rst_ni = 1'b0;
    #1;
    check_idle_outputs("midrst");
    exp_bus.delete(); exp_start.delete(); exp_done.delete();
    rd_q.delete(); acc_q.delete(); fixed_acc.delete();
    model_mem = 32'h0;
    repeat (2) @(negedge clk_i);
    #2;
    rst_ni = 1'b1;
    repeat (4) @(negedge clk_i);
    run_cmd(OP_ENCF, 3'd1, 32'h0000_0900, 3'd3, 32'hCAFE_000A, zw_latency(OP_ENCF, 3'd3));

    // Randomized commands with random bus waits.
    zero_wait = 1'b0;
    for (int i = 0; i < 30; i++) begin
      op  = 3'($urandom_range(0, 7));
      sr  = 3'($urandom_range(0, 7));
      len = 3'($urandom_range(0, 7));
      addr = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 3) == 0) addr = 32'hFFFF_FFF0;
      run_cmd(op, sr, addr, len, $urandom, -1);
    end

    repeat (4) @(negedge clk_i);
    chk("bus_exp_left", 32'(exp_bus.size()), 32'h0);
    chk("start_exp_left", 32'(exp_start.size()), 32'h0);
    chk("done_exp_left", 32'(exp_done.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
